// File: rtl/cnn_axi_slave_mem.sv
// AXI4 slave with an internal word-addressed SRAM, serving one burst at a time.
// Reads and writes are arbitrated round-robin when both requests arrive together.
module cnn_axi_slave_mem #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MEM_AW     = 12
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    s_axi_AWVALID,
    output logic                    s_axi_AWREADY,
    input  logic [ADDR_WIDTH-1:0]   s_axi_AWADDR,
    input  logic [ID_WIDTH-1:0]     s_axi_AWID,
    input  logic [7:0]              s_axi_AWLEN,
    input  logic [2:0]              s_axi_AWSIZE,
    input  logic [1:0]              s_axi_AWBURST,
    input  logic                    s_axi_WVALID,
    output logic                    s_axi_WREADY,
    input  logic [DATA_WIDTH-1:0]   s_axi_WDATA,
    input  logic [DATA_WIDTH/8-1:0] s_axi_WSTRB,
    input  logic                    s_axi_WLAST,
    output logic                    s_axi_BVALID,
    input  logic                    s_axi_BREADY,
    output logic [ID_WIDTH-1:0]     s_axi_BID,
    output logic [1:0]              s_axi_BRESP,
    input  logic                    s_axi_ARVALID,
    output logic                    s_axi_ARREADY,
    input  logic [ADDR_WIDTH-1:0]   s_axi_ARADDR,
    input  logic [ID_WIDTH-1:0]     s_axi_ARID,
    input  logic [7:0]              s_axi_ARLEN,
    input  logic [2:0]              s_axi_ARSIZE,
    input  logic [1:0]              s_axi_ARBURST,
    output logic                    s_axi_RVALID,
    input  logic                    s_axi_RREADY,
    output logic [DATA_WIDTH-1:0]   s_axi_RDATA,
    output logic [ID_WIDTH-1:0]     s_axi_RID,
    output logic [1:0]              s_axi_RRESP,
    output logic                    s_axi_RLAST
);
    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned L     = $clog2(NB);
    localparam int unsigned DEPTH = 1 << MEM_AW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WR    = 2'd1;
    localparam logic [1:0] S_WRESP = 2'd2;
    localparam logic [1:0] S_RD    = 2'd3;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [1:0]            state, state_n;
    logic [MEM_AW-1:0]     idx, idx_n, idx_adv, rd_idx;
    logic [7:0]            len, len_n, beat, beat_n;
    logic                  fixed, fixed_n, serr, serr_n, werr, werr_n;
    logic [ID_WIDTH-1:0]   id, id_n;
    logic                  last_wr, last_wr_n;
    logic                  awready, awready_n, arready, arready_n, wready, wready_n;
    logic                  bvalid, bvalid_n, rvalid, rvalid_n, rlast, rlast_n;
    logic [1:0]            bresp, bresp_n, rresp, rresp_n;
    logic [ID_WIDTH-1:0]   bid, bid_n, rid, rid_n;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rd_load, rd_zero, mem_we;
    logic                  aw_req, ar_req, beat_last, wlast_bad;

    // Address bits outside the word index are ignored, so the memory aliases.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_AWADDR[ADDR_WIDTH-1:MEM_AW+L], s_axi_AWADDR[L-1:0],
                                s_axi_ARADDR[ADDR_WIDTH-1:MEM_AW+L], s_axi_ARADDR[L-1:0]};

    assign aw_req    = awready && s_axi_AWVALID;
    assign ar_req    = arready && s_axi_ARVALID;
    assign beat_last = (beat == len);
    assign idx_adv   = fixed ? idx : idx + MEM_AW'(1);
    assign wlast_bad = (s_axi_WLAST != beat_last);

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        len_n     = len;
        beat_n    = beat;
        fixed_n   = fixed;
        serr_n    = serr;
        werr_n    = werr;
        id_n      = id;
        last_wr_n = last_wr;
        awready_n = 1'b0;
        arready_n = 1'b0;
        wready_n  = 1'b0;
        bvalid_n  = bvalid;
        bresp_n   = bresp;
        bid_n     = bid;
        rvalid_n  = rvalid;
        rlast_n   = rlast;
        rresp_n   = rresp;
        rid_n     = rid;
        rd_load   = 1'b0;
        rd_zero   = serr;
        rd_idx    = idx;
        mem_we    = 1'b0;
        unique case (state)
            S_IDLE: begin
                awready_n = 1'b1;
                arready_n = 1'b1;
                // On a conflict, grant whichever side was not served last.
                if (aw_req && (!ar_req || !last_wr)) begin
                    state_n   = S_WR;
                    idx_n     = s_axi_AWADDR[MEM_AW+L-1:L];
                    len_n     = s_axi_AWLEN;
                    beat_n    = 8'd0;
                    fixed_n   = (s_axi_AWBURST == 2'b00);
                    serr_n    = (s_axi_AWSIZE != 3'(L));
                    werr_n    = 1'b0;
                    id_n      = s_axi_AWID;
                    last_wr_n = 1'b1;
                    awready_n = 1'b0;
                    arready_n = 1'b0;
                    wready_n  = 1'b1;
                end else if (ar_req) begin
                    state_n   = S_RD;
                    idx_n     = s_axi_ARADDR[MEM_AW+L-1:L];
                    len_n     = s_axi_ARLEN;
                    beat_n    = 8'd0;
                    fixed_n   = (s_axi_ARBURST == 2'b00);
                    serr_n    = (s_axi_ARSIZE != 3'(L));
                    id_n      = s_axi_ARID;
                    last_wr_n = 1'b0;
                    awready_n = 1'b0;
                    arready_n = 1'b0;
                    rvalid_n  = 1'b1;
                    rid_n     = s_axi_ARID;
                    rresp_n   = (s_axi_ARSIZE != 3'(L)) ? SLVERR : OKAY;
                    rlast_n   = (s_axi_ARLEN == 8'd0);
                    rd_load   = 1'b1;
                    rd_idx    = s_axi_ARADDR[MEM_AW+L-1:L];
                    rd_zero   = (s_axi_ARSIZE != 3'(L));
                end
            end
            S_WR: begin
                wready_n = 1'b1;
                if (wready && s_axi_WVALID) begin
                    mem_we = !serr;
                    beat_n = beat + 8'd1;
                    idx_n  = idx_adv;
                    if (wlast_bad) werr_n = 1'b1;
                    if (beat_last) begin
                        state_n  = S_WRESP;
                        wready_n = 1'b0;
                        bvalid_n = 1'b1;
                        bresp_n  = (serr || werr || wlast_bad) ? SLVERR : OKAY;
                        bid_n    = id;
                    end
                end
            end
            S_WRESP: begin
                if (s_axi_BREADY) begin
                    state_n   = S_IDLE;
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    arready_n = 1'b1;
                end
            end
            S_RD: begin
                if (rvalid && s_axi_RREADY) begin
                    if (beat_last) begin
                        state_n   = S_IDLE;
                        rvalid_n  = 1'b0;
                        rlast_n   = 1'b0;
                        awready_n = 1'b1;
                        arready_n = 1'b1;
                    end else begin
                        beat_n  = beat + 8'd1;
                        idx_n   = idx_adv;
                        rd_load = 1'b1;
                        rd_idx  = idx_adv;
                        rlast_n = ((beat + 8'd1) == len);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and registered outputs; read data comes from a synchronous SRAM read.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            len     <= '0;
            beat    <= '0;
            fixed   <= 1'b0;
            serr    <= 1'b0;
            werr    <= 1'b0;
            id      <= '0;
            last_wr <= 1'b1;
            awready <= 1'b0;
            arready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
            bid     <= '0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rresp   <= OKAY;
            rid     <= '0;
            rdata   <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            len     <= len_n;
            beat    <= beat_n;
            fixed   <= fixed_n;
            serr    <= serr_n;
            werr    <= werr_n;
            id      <= id_n;
            last_wr <= last_wr_n;
            awready <= awready_n;
            arready <= arready_n;
            wready  <= wready_n;
            bvalid  <= bvalid_n;
            bresp   <= bresp_n;
            bid     <= bid_n;
            rvalid  <= rvalid_n;
            rlast   <= rlast_n;
            rresp   <= rresp_n;
            rid     <= rid_n;
            if (rd_load) rdata <= rd_zero ? '0 : mem[rd_idx];
        end
    end

    // Byte-lane write port; contents survive reset.
    always_ff @(posedge ap_clk) begin
        if (mem_we) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (s_axi_WSTRB[b]) mem[idx][b*8 +: 8] <= s_axi_WDATA[b*8 +: 8];
            end
        end
    end

    assign s_axi_AWREADY = awready;
    assign s_axi_ARREADY = arready;
    assign s_axi_WREADY  = wready;
    assign s_axi_BVALID  = bvalid;
    assign s_axi_BRESP   = bresp;
    assign s_axi_BID     = bid;
    assign s_axi_RVALID  = rvalid;
    assign s_axi_RDATA   = rdata;
    assign s_axi_RID     = rid;
    assign s_axi_RRESP   = rresp;
    assign s_axi_RLAST   = rlast;

endmodule

// File: tb/tb_cnn_axi_slave_mem.sv
// Directed bench for cnn_axi_slave_mem: bursts, strobes, stalls, arbitration,
// error responses, address wrap/alias and reset during a read burst.
module tb_cnn_axi_slave_mem;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;

    logic        ap_clk, ap_rst_n;
    logic        s_axi_AWVALID, s_axi_AWREADY;
    logic [31:0] s_axi_AWADDR;
    logic [3:0]  s_axi_AWID;
    logic [7:0]  s_axi_AWLEN;
    logic [2:0]  s_axi_AWSIZE;
    logic [1:0]  s_axi_AWBURST;
    logic        s_axi_WVALID, s_axi_WREADY;
    logic [63:0] s_axi_WDATA;
    logic [7:0]  s_axi_WSTRB;
    logic        s_axi_WLAST;
    logic        s_axi_BVALID, s_axi_BREADY;
    logic [3:0]  s_axi_BID;
    logic [1:0]  s_axi_BRESP;
    logic        s_axi_ARVALID, s_axi_ARREADY;
    logic [31:0] s_axi_ARADDR;
    logic [3:0]  s_axi_ARID;
    logic [7:0]  s_axi_ARLEN;
    logic [2:0]  s_axi_ARSIZE;
    logic [1:0]  s_axi_ARBURST;
    logic        s_axi_RVALID, s_axi_RREADY;
    logic [63:0] s_axi_RDATA;
    logic [3:0]  s_axi_RID;
    logic [1:0]  s_axi_RRESP;
    logic        s_axi_RLAST;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] wd [0:15];
    logic [63:0] ex [0:15];

    cnn_axi_slave_mem dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_axi_AWVALID(s_axi_AWVALID), .s_axi_AWREADY(s_axi_AWREADY),
        .s_axi_AWADDR(s_axi_AWADDR), .s_axi_AWID(s_axi_AWID), .s_axi_AWLEN(s_axi_AWLEN),
        .s_axi_AWSIZE(s_axi_AWSIZE), .s_axi_AWBURST(s_axi_AWBURST),
        .s_axi_WVALID(s_axi_WVALID), .s_axi_WREADY(s_axi_WREADY),
        .s_axi_WDATA(s_axi_WDATA), .s_axi_WSTRB(s_axi_WSTRB), .s_axi_WLAST(s_axi_WLAST),
        .s_axi_BVALID(s_axi_BVALID), .s_axi_BREADY(s_axi_BREADY),
        .s_axi_BID(s_axi_BID), .s_axi_BRESP(s_axi_BRESP),
        .s_axi_ARVALID(s_axi_ARVALID), .s_axi_ARREADY(s_axi_ARREADY),
        .s_axi_ARADDR(s_axi_ARADDR), .s_axi_ARID(s_axi_ARID), .s_axi_ARLEN(s_axi_ARLEN),
        .s_axi_ARSIZE(s_axi_ARSIZE), .s_axi_ARBURST(s_axi_ARBURST),
        .s_axi_RVALID(s_axi_RVALID), .s_axi_RREADY(s_axi_RREADY),
        .s_axi_RDATA(s_axi_RDATA), .s_axi_RID(s_axi_RID), .s_axi_RRESP(s_axi_RRESP),
        .s_axi_RLAST(s_axi_RLAST)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int to = 0;
        while (!(s_axi_ARREADY && s_axi_AWREADY) && to < 20) begin
            tick();
            to++;
        end
        check({tag, "_idle_timeout"}, 64'(to >= 20), 64'd0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb,
                            input int last_at, input logic [1:0] exp_resp, input string tag);
        int to;
        bit tmo = 1'b0;
        wait_idle(tag);
        s_axi_AWADDR = addr; s_axi_AWID = id; s_axi_AWLEN = len;
        s_axi_AWSIZE = size; s_axi_AWBURST = burst; s_axi_AWVALID = 1'b1;
        tick();
        s_axi_AWVALID = 1'b0;
        check({tag, "_wready_lat"}, 64'(s_axi_WREADY), 64'd1);
        for (int i = 0; i <= int'(len); i++) begin
            s_axi_WVALID = 1'b1; s_axi_WDATA = wd[i]; s_axi_WSTRB = strb;
            s_axi_WLAST = (i == last_at);
            to = 0;
            while (!s_axi_WREADY && to < 20) begin
                tick();
                to++;
            end
            if (to >= 20) tmo = 1'b1;
            tick();
        end
        s_axi_WVALID = 1'b0; s_axi_WLAST = 1'b0;
        check({tag, "_w_timeout"}, 64'(tmo), 64'd0);
        check({tag, "_bvalid"}, 64'(s_axi_BVALID), 64'd1);
        check({tag, "_bresp"}, 64'(s_axi_BRESP), 64'(exp_resp));
        check({tag, "_bid"}, 64'(s_axi_BID), 64'(id));
        s_axi_BREADY = 1'b1;
        tick();
        s_axi_BREADY = 1'b0;
        check({tag, "_bvalid_done"}, 64'(s_axi_BVALID), 64'd0);
    endtask

    // Checks every R beat against ex[]; toggle drives RREADY 1,0,0,1,0,0...
    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                           input logic [1:0] exp_resp, input string tag);
        int beats = 0;
        int cyc = 0;
        wait_idle(tag);
        s_axi_ARADDR = addr; s_axi_ARID = id; s_axi_ARLEN = len;
        s_axi_ARSIZE = size; s_axi_ARBURST = burst; s_axi_ARVALID = 1'b1;
        tick();
        s_axi_ARVALID = 1'b0;
        check({tag, "_rvalid_lat"}, 64'(s_axi_RVALID), 64'd1);
        while (beats <= int'(len) && cyc < 100) begin
            s_axi_RREADY = toggle ? (cyc % 3 == 0) : 1'b1;
            if (s_axi_RVALID) begin
                check($sformatf("%s_rdata%0d", tag, beats), s_axi_RDATA, ex[beats]);
                check($sformatf("%s_rlast%0d", tag, beats), 64'(s_axi_RLAST), 64'(beats == int'(len)));
                check($sformatf("%s_rresp%0d", tag, beats), 64'(s_axi_RRESP), 64'(exp_resp));
                check($sformatf("%s_rid%0d", tag, beats), 64'(s_axi_RID), 64'(id));
                if (s_axi_RREADY) beats++;
            end
            tick();
            cyc++;
        end
        s_axi_RREADY = 1'b0;
        check({tag, "_beats"}, 64'(beats), 64'(int'(len) + 1));
        check({tag, "_rvalid_done"}, 64'(s_axi_RVALID), 64'd0);
    endtask

    initial begin
        ap_rst_n = 1'b0;
        s_axi_AWVALID = 1'b0; s_axi_AWADDR = '0; s_axi_AWID = '0; s_axi_AWLEN = '0;
        s_axi_AWSIZE = 3'd3; s_axi_AWBURST = INCR;
        s_axi_WVALID = 1'b0; s_axi_WDATA = '0; s_axi_WSTRB = '0; s_axi_WLAST = 1'b0;
        s_axi_BREADY = 1'b0;
        s_axi_ARVALID = 1'b0; s_axi_ARADDR = '0; s_axi_ARID = '0; s_axi_ARLEN = '0;
        s_axi_ARSIZE = 3'd3; s_axi_ARBURST = INCR;
        s_axi_RREADY = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_awready", 64'(s_axi_AWREADY), 64'd0);
        check("rst_arready", 64'(s_axi_ARREADY), 64'd0);
        check("rst_wready", 64'(s_axi_WREADY), 64'd0);
        check("rst_bvalid", 64'(s_axi_BVALID), 64'd0);
        check("rst_rvalid", 64'(s_axi_RVALID), 64'd0);
        check("rst_rdata", s_axi_RDATA, 64'd0);
        check("rst_rlast", 64'(s_axi_RLAST), 64'd0);
        check("rst_bresp", 64'(s_axi_BRESP), 64'd0);
        ap_rst_n = 1'b1;
        tick();
        check("rel_arready", 64'(s_axi_ARREADY), 64'd1);
        check("rel_awready", 64'(s_axi_AWREADY), 64'd1);

        // Arbitration: both requests on three consecutive transactions -> read, write, read
        s_axi_AWADDR = 32'h600; s_axi_AWID = 4'h1; s_axi_AWLEN = 8'd0; s_axi_AWSIZE = 3'd3;
        s_axi_ARADDR = 32'h600; s_axi_ARID = 4'h2; s_axi_ARLEN = 8'd0; s_axi_ARSIZE = 3'd3;
        s_axi_AWVALID = 1'b1; s_axi_ARVALID = 1'b1;
        tick();
        check("arb1_rvalid", 64'(s_axi_RVALID), 64'd1);
        check("arb1_wready", 64'(s_axi_WREADY), 64'd0);
        check("arb1_rid", 64'(s_axi_RID), 64'h2);
        s_axi_ARVALID = 1'b0; s_axi_RREADY = 1'b1;
        tick();
        s_axi_RREADY = 1'b0; s_axi_ARVALID = 1'b1;
        tick();
        check("arb2_wready", 64'(s_axi_WREADY), 64'd1);
        check("arb2_rvalid", 64'(s_axi_RVALID), 64'd0);
        s_axi_AWVALID = 1'b0;
        s_axi_WVALID = 1'b1; s_axi_WDATA = 64'h5A; s_axi_WSTRB = 8'hFF; s_axi_WLAST = 1'b1;
        tick();
        s_axi_WVALID = 1'b0; s_axi_WLAST = 1'b0;
        check("arb2_bvalid", 64'(s_axi_BVALID), 64'd1);
        check("arb2_bid", 64'(s_axi_BID), 64'h1);
        s_axi_BREADY = 1'b1;
        tick();
        s_axi_BREADY = 1'b0; s_axi_AWVALID = 1'b1;
        tick();
        check("arb3_rvalid", 64'(s_axi_RVALID), 64'd1);
        check("arb3_wready", 64'(s_axi_WREADY), 64'd0);
        check("arb3_rdata", s_axi_RDATA, 64'h5A);
        s_axi_AWVALID = 1'b0; s_axi_ARVALID = 1'b0; s_axi_RREADY = 1'b1;
        tick();
        s_axi_RREADY = 1'b0;

        // INCR burst write and readback
        wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
        do_write(32'h100, 4'h3, 8'd3, 3'd3, INCR, 8'hFF, 3, OKAY, "w_incr");
        ex[0] = 64'h11; ex[1] = 64'h22; ex[2] = 64'h33; ex[3] = 64'h44;
        do_read(32'h100, 4'h3, 8'd3, 3'd3, INCR, 1'b0, OKAY, "r_incr");

        // Partial strobe merges into the existing word
        wd[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        do_write(32'h300, 4'h2, 8'd0, 3'd3, INCR, 8'hFF, 0, OKAY, "w_full");
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_write(32'h300, 4'h2, 8'd0, 3'd3, INCR, 8'h0F, 0, OKAY, "w_strb");
        ex[0] = 64'hAAAA_AAAA_FFFF_FFFF;
        do_read(32'h300, 4'h2, 8'd0, 3'd3, INCR, 1'b0, OKAY, "r_strb");

        // Stalled read holds RDATA/RLAST steady
        ex[0] = 64'h11; ex[1] = 64'h22; ex[2] = 64'h33; ex[3] = 64'h44;
        do_read(32'h100, 4'h5, 8'd3, 3'd3, INCR, 1'b1, OKAY, "r_stall");

        // Size error: zero data, SLVERR; a size-error write leaves memory untouched
        ex[0] = 64'd0; ex[1] = 64'd0; ex[2] = 64'd0; ex[3] = 64'd0;
        do_read(32'h100, 4'h6, 8'd3, 3'd2, INCR, 1'b0, SLVERR, "r_size");
        wd[0] = 64'd0;
        do_write(32'h300, 4'h4, 8'd0, 3'd2, INCR, 8'hFF, 0, SLVERR, "w_size");
        ex[0] = 64'hAAAA_AAAA_FFFF_FFFF;
        do_read(32'h300, 4'h4, 8'd0, 3'd3, INCR, 1'b0, OKAY, "r_after_wsize");

        // Early WLAST: all beats still consumed and written, BRESP=SLVERR
        wd[0] = 64'h1; wd[1] = 64'h2; wd[2] = 64'h3; wd[3] = 64'h4;
        do_write(32'h400, 4'h7, 8'd3, 3'd3, INCR, 8'hFF, 1, SLVERR, "w_wlast");
        ex[0] = 64'h1; ex[1] = 64'h2; ex[2] = 64'h3; ex[3] = 64'h4;
        do_read(32'h400, 4'h7, 8'd3, 3'd3, INCR, 1'b0, OKAY, "r_wlast");

        // FIXED burst keeps hitting one word
        wd[0] = 64'd0; wd[1] = 64'd0;
        do_write(32'h500, 4'h1, 8'd1, 3'd3, INCR, 8'hFF, 1, OKAY, "w_clr");
        wd[0] = 64'h5; wd[1] = 64'h6; wd[2] = 64'h7;
        do_write(32'h500, 4'h1, 8'd2, 3'd3, FIXED, 8'hFF, 2, OKAY, "w_fixed");
        ex[0] = 64'h7; ex[1] = 64'd0;
        do_read(32'h500, 4'h1, 8'd1, 3'd3, INCR, 1'b0, OKAY, "r_fixed");

        // Index wraps at the top of memory; upper address bits alias
        wd[0] = 64'hA1; wd[1] = 64'hA2;
        do_write(32'h7FF8, 4'h9, 8'd1, 3'd3, INCR, 8'hFF, 1, OKAY, "w_wrap");
        ex[0] = 64'hA1; ex[1] = 64'hA2;
        do_read(32'h0001_7FF8, 4'h9, 8'd1, 3'd3, INCR, 1'b0, OKAY, "r_alias");
        ex[0] = 64'hA2;
        do_read(32'h0, 4'h9, 8'd0, 3'd3, INCR, 1'b0, OKAY, "r_wrap0");

        // Reset during beat 2 of an 8-beat read
        wait_idle("rst_rd");
        s_axi_ARADDR = 32'h100; s_axi_ARID = 4'h8; s_axi_ARLEN = 8'd7;
        s_axi_ARSIZE = 3'd3; s_axi_ARBURST = INCR; s_axi_ARVALID = 1'b1;
        tick();
        s_axi_ARVALID = 1'b0;
        check("rst_rd_beat1", s_axi_RDATA, 64'h11);
        s_axi_RREADY = 1'b1;
        tick();
        s_axi_RREADY = 1'b0;
        check("rst_rd_beat2", s_axi_RDATA, 64'h22);
        check("rst_rd_rvalid_pre", 64'(s_axi_RVALID), 64'd1);
        #2 ap_rst_n = 1'b0;
        #1;
        check("rst_rd_rvalid_async", 64'(s_axi_RVALID), 64'd0);
        check("rst_rd_arready_held", 64'(s_axi_ARREADY), 64'd0);
        tick();
        ap_rst_n = 1'b1;
        tick();
        check("rst_rd_arready_rel", 64'(s_axi_ARREADY), 64'd1);
        check("rst_rd_rvalid_rel", 64'(s_axi_RVALID), 64'd0);
        ex[0] = 64'h11; ex[1] = 64'h22; ex[2] = 64'h33; ex[3] = 64'h44;
        do_read(32'h100, 4'h8, 8'd3, 3'd3, INCR, 1'b0, OKAY, "r_post_rst");
        ex[0] = 64'hAAAA_AAAA_FFFF_FFFF;
        do_read(32'h300, 4'h8, 8'd0, 3'd3, INCR, 1'b0, OKAY, "r_post_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
